// File: rtl/bn_sequencer.sv
`default_nettype none
// ==========================================================================
// bn_sequencer - time-multiplexes one batch-normalization datapath over a
// layer of NEURONS neurons and owns the per-neuron BN parameter bank.
// Revision: 1.0
// ==========================================================================
module bn_sequencer #(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2,
  parameter int NEURONS      = 4,
  parameter int IDX_W        = $clog2(NEURONS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic [3:0]                  cfg_factor,
  input  logic [ADDEND_WIDTH-1:0]     cfg_addend,
  output logic                        cfg_ready,
  output logic                        cfg_err,
  input  logic                        start,
  input  logic [NEURONS*WIDTH-1:0]    u_vec,
  input  logic [NEURONS*WIDTH-1:0]    z_vec,
  output logic [WIDTH-1:0]            bn_u,
  output logic [WIDTH-1:0]            bn_z,
  output logic [3:0]                  bn_factor,
  output logic [ADDEND_WIDTH-1:0]     bn_addend,
  input  logic [WIDTH-1:0]            bn_u_out,
  output logic [NEURONS*WIDTH-1:0]    u_out_vec,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NEURONS - 1);
  localparam logic [IDX_W:0]   NEURONS_EXT  = (IDX_W + 1)'(NEURONS);
  localparam logic [3:0]       FACTOR_UNITY = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [NEURONS*WIDTH-1:0]    snap_u;
  logic [NEURONS*WIDTH-1:0]    snap_z;
  logic [NEURONS*WIDTH-1:0]    shadow;
  logic [3:0]                  bank_factor [NEURONS];
  logic [ADDEND_WIDTH-1:0]     bank_addend [NEURONS];
  logic                        cfg_bad;
  logic                        cfg_write;

  assign cfg_ready = (state == S_IDLE) && !start;
  assign cfg_write = cfg_valid && cfg_ready;

  // Codes the datapath cannot execute, plus the zero-only-addend code 0011.
  always_comb begin
    cfg_bad = 1'b0;
    if (cfg_factor == 4'b0000 || cfg_factor == 4'b0111 ||
        cfg_factor == 4'b1011 || cfg_factor == 4'b1111)
      cfg_bad = 1'b1;
    if (cfg_factor == 4'b0011 && cfg_addend != '0)
      cfg_bad = 1'b1;
    if ({1'b0, cfg_idx} >= NEURONS_EXT)
      cfg_bad = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        bank_factor[i] <= FACTOR_UNITY;
        bank_addend[i] <= '0;
      end
    end else if (cfg_write) begin
      if (cfg_bad) begin
        cfg_err <= 1'b1;
      end else begin
        for (int i = 0; i < NEURONS; i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            bank_factor[i] <= cfg_factor;
            bank_addend[i] <= cfg_addend;
          end
        end
      end
    end
  end

  assign bn_u      = snap_u[idx*WIDTH +: WIDTH];
  assign bn_z      = snap_z[idx*WIDTH +: WIDTH];
  assign bn_factor = bank_factor[idx];
  assign bn_addend = bank_addend[idx];

  // Results collect in shadow and are published together on leaving DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      snap_u    <= '0;
      snap_z    <= '0;
      shadow    <= '0;
      u_out_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            snap_u <= u_vec;
            snap_z <= z_vec;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          shadow[idx*WIDTH +: WIDTH] <= bn_u_out;
          if (idx == LAST_IDX)
            state <= S_DONE;
          else
            idx <= idx + IDX_W'(1);
        end
        S_DONE: begin
          u_out_vec <= shadow;
          done      <= 1'b1;
          busy      <= 1'b0;
          idx       <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bn_sequencer.sv
`default_nettype none
// Bench for bn_sequencer: a behavioural stand-in for the shared datapath plus
// a layer-level reference model (parameter bank + per-neuron formula).
module tb_bn_sequencer;

  localparam int WIDTH        = 6;
  localparam int ADDEND_WIDTH = WIDTH - 2;
  localparam int NEURONS      = 4;
  localparam int IDX_W        = $clog2(NEURONS);
  localparam int VW           = NEURONS * WIDTH;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     cfg_valid = 1'b0;
  logic [IDX_W-1:0]         cfg_idx = '0;
  logic [3:0]               cfg_factor = 4'b0100;
  logic [ADDEND_WIDTH-1:0]  cfg_addend = '0;
  logic                     cfg_ready;
  logic                     cfg_err;
  logic                     start = 1'b0;
  logic [VW-1:0]            u_vec = '0;
  logic [VW-1:0]            z_vec = '0;
  logic [WIDTH-1:0]         bn_u;
  logic [WIDTH-1:0]         bn_z;
  logic [3:0]               bn_factor;
  logic [ADDEND_WIDTH-1:0]  bn_addend;
  logic [WIDTH-1:0]         bn_u_out;
  logic [VW-1:0]            u_out_vec;
  logic                     busy;
  logic                     done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the bank and sticky flag should hold.
  logic [3:0]               m_factor [NEURONS];
  logic [ADDEND_WIDTH-1:0]  m_addend [NEURONS];
  logic                     m_err;
  logic [VW-1:0]            m_out;

  bn_sequencer #(
    .WIDTH(WIDTH), .ADDEND_WIDTH(ADDEND_WIDTH), .NEURONS(NEURONS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_factor(cfg_factor),
    .cfg_addend(cfg_addend), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .start(start), .u_vec(u_vec), .z_vec(z_vec),
    .bn_u(bn_u), .bn_z(bn_z), .bn_factor(bn_factor), .bn_addend(bn_addend),
    .bn_u_out(bn_u_out), .u_out_vec(u_out_vec), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Saturating u + factor*z + addend with a small factor-code table.
  function automatic logic [WIDTH-1:0] dp(input logic signed [WIDTH-1:0] u,
                                          input logic signed [WIDTH-1:0] z,
                                          input logic [3:0] f,
                                          input logic signed [ADDEND_WIDTH-1:0] a);
    int zs;
    int acc;
    case (f)
      4'b1000: zs = int'(z) >>> 2;
      4'b0010: zs = int'(z) * 2;
      4'b1110: zs = int'(z) * 6;
      default: zs = int'(z);
    endcase
    acc = int'(u) + zs + int'(a);
    if (acc > 31)  acc = 31;
    if (acc < -32) acc = -32;
    return acc[WIDTH-1:0];
  endfunction

  assign bn_u_out = dp(bn_u, bn_z, bn_factor, bn_addend);

  function automatic logic [VW-1:0] model_layer(input logic [VW-1:0] u, input logic [VW-1:0] z);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NEURONS; i++)
      r[i*WIDTH +: WIDTH] = dp(u[i*WIDTH +: WIDTH], z[i*WIDTH +: WIDTH], m_factor[i], m_addend[i]);
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < NEURONS; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NEURONS; i++) begin
      m_factor[i] = 4'b0100;
      m_addend[i] = '0;
    end
    m_err = 1'b0;
    m_out = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int i, input logic [3:0] f, input logic [ADDEND_WIDTH-1:0] a);
    cfg_valid = 1'b1;
    cfg_idx = i[IDX_W-1:0];
    cfg_factor = f;
    cfg_addend = a;
    tick();
    cfg_valid = 1'b0;
    if (f == 4'b0000 || f == 4'b0111 || f == 4'b1011 || f == 4'b1111 ||
        (f == 4'b0011 && a != '0) || i >= NEURONS)
      m_err = 1'b1;
    else begin
      m_factor[i] = f;
      m_addend[i] = a;
    end
    chk("cfg_err", cfg_err, m_err);
  endtask

  // One pass; optional same-cycle config write and a stray start during RUN.
  task automatic run_pass(input logic [VW-1:0] u, input logic [VW-1:0] z,
                          input bit collide, input bit poke);
    logic [VW-1:0] exp;
    exp = model_layer(u, z);
    u_vec = u;
    z_vec = z;
    start = 1'b1;
    if (collide) begin
      cfg_valid = 1'b1; cfg_idx = '0; cfg_factor = 4'b0010; cfg_addend = 4'd1;
    end
    #1;
    chk("ready_low_on_start", cfg_ready, 1'b0);
    tick();
    start = 1'b0;
    cfg_valid = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int c = 1; c <= NEURONS + 1; c++) begin
      if (poke && c == 2) start = 1'b1;
      if (poke && c == 3) start = 1'b0;
      tick();
      if (c <= NEURONS) begin
        chk("busy_run", busy, 1'b1);
        chk("done_early", done, 1'b0);
        chk("out_held", u_out_vec, m_out);
      end else begin
        chk("busy_end", busy, 1'b0);
        chk("done_pulse", done, 1'b1);
        chk("u_out_vec", u_out_vec, exp);
      end
    end
    m_out = exp;
    tick();
    chk("done_single", done, 1'b0);
    chk("ready_idle", cfg_ready, 1'b1);
    chk("cfg_err_after_pass", cfg_err, m_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] hu [32];
    logic [VW-1:0] hz [32];
    int s;
    bit exp_done;

    model_reset();
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_out", u_out_vec, '0);
    chk("rst_factor", bn_factor, 4'b0100);
    reset = 1'b0;
    tick();
    chk("rst_ready", cfg_ready, 1'b1);

    // Pass-through with default bank.
    run_pass({6'd4, 6'd3, 6'd2, 6'd1}, {4{6'd5}}, 1'b0, 1'b0);
    chk("passthru_const", u_out_vec, {6'd9, 6'd8, 6'd7, 6'd6});

    // Per-neuron parameters.
    cfg_write(0, 4'b1000, 4'd1);
    cfg_write(1, 4'b0010, 4'd0);
    cfg_write(2, 4'b0011, 4'd0);
    cfg_write(3, 4'b1110, 4'b1110);
    run_pass({6'd0, 6'd31, 6'd3, 6'd0}, {6'd1, 6'd31, 6'd4, 6'h38}, 1'b0, 1'b0);
    chk("per_neuron_const", u_out_vec, {6'd4, 6'd31, 6'd11, 6'h3F});

    // Collisions: same-cycle write dropped, stray start during RUN ignored.
    run_pass(rnd_vec(), rnd_vec(), 1'b1, 1'b0);
    chk("collide_no_err", cfg_err, 1'b0);
    run_pass(rnd_vec(), rnd_vec(), 1'b0, 1'b1);

    // Rejected writes leave the bank untouched.
    cfg_write(1, 4'b0111, 4'd0);
    cfg_write(0, 4'b0011, 4'd1);
    cfg_write(2, 4'b0000, 4'd3);
    chk("reject_err", cfg_err, 1'b1);
    run_pass(rnd_vec(), rnd_vec(), 1'b0, 1'b0);

    // Reset in the middle of a pass.
    u_vec = rnd_vec();
    z_vec = rnd_vec();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", cfg_err, 1'b0);
    chk("midrst_out", u_out_vec, '0);
    chk("midrst_factor", bn_factor, 4'b0100);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < NEURONS + 3; c++) begin
      tick();
      chk("midrst_no_done", done, 1'b0);
    end
    run_pass(rnd_vec(), rnd_vec(), 1'b0, 1'b0);

    // Random configuration, legal and illegal codes alike.
    for (int w = 0; w < 10; w++)
      cfg_write(int'($urandom_range(0, NEURONS - 1)), 4'($urandom), ADDEND_WIDTH'($urandom));
    run_pass(rnd_vec(), rnd_vec(), 1'b0, 1'b0);

    // Back-to-back: start held for 20 cycles, fresh vectors every cycle.
    for (int e = 0; e < 26; e++) begin
      hu[e] = rnd_vec();
      hz[e] = rnd_vec();
      u_vec = hu[e];
      z_vec = hz[e];
      start = (e < 20);
      tick();
      s = e - (NEURONS + 1);
      exp_done = (s >= 0) && (s % (NEURONS + 2) == 0) && (s < 20);
      chk("b2b_done", done, exp_done);
      if (exp_done) chk("b2b_out", u_out_vec, model_layer(hu[s], hz[s]));
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
